// File: rtl/shift_add_datapath.sv
// Datapath of a 32x32 unsigned shift-add multiplier: multiplicand register,
// 64-bit product/multiplier register and result-valid flag.
// Optional step checker is enabled by defining DP_STEP_CHECK_EN.
module shift_add_datapath (
  input  logic        clk,
  input  logic        Reset,
  input  logic        W_ctrl,
  input  logic [5:0]  ADDU_ctrl,
  input  logic        SRL_ctrl,
  input  logic        Ready,
  input  logic [31:0] Multiplicand_in,
  input  logic [31:0] Multiplier_in,
  output logic        LSB,
  output logic [63:0] Product,
`ifdef DP_STEP_CHECK_EN
  output logic        Step_err,
`endif
  output logic        Valid
);

  localparam logic [5:0] ADDU_ADD = 6'b001001;

  logic [31:0] mcand_q, mcand_d;
  logic [63:0] product_q, product_d;
  logic        valid_q, valid_d;
  logic        add_sel;
  logic [32:0] sum;

  // The sum keeps the adder carry as bit 32 so it lands in Product[63] on the shift.
  assign add_sel = (ADDU_ctrl == ADDU_ADD);
  assign sum     = {1'b0, product_q[63:32]} + (add_sel ? {1'b0, mcand_q} : 33'd0);

  // Priority per edge: load, then Ready (freeze, flag result), then add/shift step, else hold.
  always_comb begin
    mcand_d   = mcand_q;
    product_d = product_q;
    valid_d   = valid_q;
    if (W_ctrl) begin
      mcand_d   = Multiplicand_in;
      product_d = {32'd0, Multiplier_in};
      valid_d   = 1'b0;
    end else if (Ready) begin
      valid_d   = 1'b1;
    end else if (SRL_ctrl) begin
      product_d = {sum, product_q[31:1]};
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      mcand_q   <= 32'd0;
      product_q <= 64'd0;
      valid_q   <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      product_q <= product_d;
      valid_q   <= valid_d;
    end
  end

  assign Product = product_q;
  assign LSB     = product_q[0];
  assign Valid   = valid_q;

`ifdef DP_STEP_CHECK_EN
  logic [5:0] step_cnt_q, step_cnt_d;
  logic       step_err_q, step_err_d;

  // Counter saturates so a runaway controller cannot wrap back to a legal count.
  always_comb begin
    step_cnt_d = step_cnt_q;
    step_err_d = step_err_q;
    if (W_ctrl) begin
      step_cnt_d = 6'd0;
      step_err_d = 1'b0;
    end else if (Ready) begin
      if (step_cnt_q != 6'd32) step_err_d = 1'b1;
    end else if (SRL_ctrl) begin
      if (step_cnt_q == 6'd32) step_err_d = 1'b1;
      if (step_cnt_q != 6'd63) step_cnt_d = step_cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      step_cnt_q <= 6'd0;
      step_err_q <= 1'b0;
    end else begin
      step_cnt_q <= step_cnt_d;
      step_err_q <= step_err_d;
    end
  end

  assign Step_err = step_err_q;
`endif

endmodule

// File: tb/tb_shift_add_datapath.sv
// Directed bench for shift_add_datapath: loads, 32-step multiplies driven by a
// bench-side controller, priority/hold cases, async reset and the optional step checker.
module tb_shift_add_datapath;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        W_ctrl = 1'b0;
  logic [5:0]  ADDU_ctrl = 6'd0;
  logic        SRL_ctrl = 1'b0;
  logic        Ready = 1'b0;
  logic [31:0] Multiplicand_in = 32'd0;
  logic [31:0] Multiplier_in = 32'd0;
  logic        LSB;
  logic [63:0] Product;
  logic        Valid;
`ifdef DP_STEP_CHECK_EN
  logic        Step_err;
`endif

  shift_add_datapath dut (
    .clk             (clk),
    .Reset           (Reset),
    .W_ctrl          (W_ctrl),
    .ADDU_ctrl       (ADDU_ctrl),
    .SRL_ctrl        (SRL_ctrl),
    .Ready           (Ready),
    .Multiplicand_in (Multiplicand_in),
    .Multiplier_in   (Multiplier_in),
    .LSB             (LSB),
    .Product         (Product),
`ifdef DP_STEP_CHECK_EN
    .Step_err        (Step_err),
`endif
    .Valid           (Valid)
  );

  always #5 clk = ~clk;

  logic [63:0] exp_q[$];
  logic [63:0] m_prod;
  logic [31:0] m_mcand;
  logic [63:0] held;
  int checks = 0;
  int errors = 0;

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b);
    W_ctrl = 1'b1; SRL_ctrl = 1'b0; Ready = 1'b0;
    Multiplicand_in = a; Multiplier_in = b;
    tick();
    W_ctrl = 1'b0;
    m_prod  = {32'd0, b};
    m_mcand = a;
    exp_q.push_back({32'd0, a} * {32'd0, b});
    check64("load_product", Product, {32'd0, b});
    check1("load_valid", Valid, 1'b0);
  endtask

  // Controller decision uses the model's LSB; any non-add code must act as add-zero.
  task automatic do_step(input bit chk);
    logic        add;
    logic [32:0] s;
    logic [5:0]  other;
    add = m_prod[0];
    other = 6'(($urandom_range(0, 62) + 10) % 64);
    ADDU_ctrl = add ? 6'b001001 : other;
    SRL_ctrl = 1'b1;
    tick();
    SRL_ctrl = 1'b0;
    s = {1'b0, m_prod[63:32]} + (add ? {1'b0, m_mcand} : 33'd0);
    m_prod = {s, m_prod[31:1]};
    if (chk) begin
      check64("step_product", Product, m_prod);
      check1("step_lsb", LSB, m_prod[0]);
    end
  endtask

  task automatic finish_mult(input string tag);
    logic [63:0] e;
    check1("pre_ready_valid", Valid, 1'b0);
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
    check1("ready_valid", Valid, 1'b1);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s scoreboard empty observed=%h expected=none", tag, Product);
    end else begin
      e = exp_q.pop_front();
      check64(tag, Product, e);
    end
  endtask

  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input string tag);
    load(a, b);
    for (int i = 0; i < 32; i++) do_step(i % 8 == 7);
`ifdef DP_STEP_CHECK_EN
    check1("step_err_32", Step_err, 1'b0);
`endif
    finish_mult(tag);
  endtask

  initial begin
    #2 Reset = 1'b1;
    #1;
    check64("reset_product", Product, 64'd0);
    check1("reset_lsb", LSB, 1'b0);
    check1("reset_valid", Valid, 1'b0);
    tick();
    tick();
    Reset = 1'b0;
    tick();

    run_mult(32'd3, 32'd5, "mult_3x5");
    check64("mult_3x5_abs", Product, 64'd15);
    run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, "mult_max");
    check64("mult_max_abs", Product, 64'hFFFFFFFE00000001);

    // Frozen after Valid: steps with Ready high must not move Product.
    held = Product;
    Ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      SRL_ctrl = i[0] ? 1'b0 : 1'b1;
      ADDU_ctrl = i[0] ? 6'b000000 : 6'b001001;
      tick();
    end
    Ready = 1'b0; SRL_ctrl = 1'b0;
    check64("freeze_product", Product, held);
    check1("freeze_valid", Valid, 1'b1);
`ifdef DP_STEP_CHECK_EN
    check1("freeze_step_err", Step_err, 1'b0);
`endif

    tick();
    tick();
    check64("idle_product", Product, held);
    check1("idle_valid", Valid, 1'b1);

    // Load wins over simultaneous step and Ready.
    W_ctrl = 1'b1; SRL_ctrl = 1'b1; Ready = 1'b1; ADDU_ctrl = 6'b001001;
    Multiplicand_in = 32'd7; Multiplier_in = 32'd9;
    tick();
    W_ctrl = 1'b0; SRL_ctrl = 1'b0; Ready = 1'b0;
    check64("prio_product", Product, 64'h0000000000000009);
    check1("prio_valid", Valid, 1'b0);

    // Async reset mid-multiply, inputs ignored while held.
    load($urandom, $urandom);
    void'(exp_q.pop_back());
    for (int i = 0; i < 10; i++) do_step(1'b0);
    #2 Reset = 1'b1;
    #1;
    check64("async_rst_product", Product, 64'd0);
    check1("async_rst_lsb", LSB, 1'b0);
    check1("async_rst_valid", Valid, 1'b0);
    W_ctrl = 1'b1; Multiplicand_in = 32'd11; Multiplier_in = 32'd13;
    tick();
    check64("rst_hold_product", Product, 64'd0);
    W_ctrl = 1'b0;
    Reset = 1'b0;
    tick();
    run_mult(32'd2, 32'd4, "mult_2x4");
    check64("mult_2x4_abs", Product, 64'd8);

    for (int n = 0; n < 3; n++) run_mult($urandom, $urandom, "mult_rand");
    run_mult(32'h80000000, 32'h00000002, "mult_msb");
    run_mult(32'd0, 32'hDEADBEEF, "mult_zero");

`ifdef DP_STEP_CHECK_EN
    load(32'd1, 32'd1);
    for (int i = 0; i < 32; i++) do_step(1'b0);
    check1("step_err_before_33", Step_err, 1'b0);
    do_step(1'b0);
    check1("step_err_33", Step_err, 1'b1);
    load(32'd1, 32'd1);
    check1("step_err_cleared", Step_err, 1'b0);
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
    check1("step_err_early_ready", Step_err, 1'b1);
    load(32'd1, 32'd1);
    check1("step_err_reload", Step_err, 1'b0);
    exp_q.delete();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
